idct_matrix_engine: RTL and testbench

Parametrised N×N signed matrix-multiply engine for the IDCT stage. It computes either T = A·C (row pass) or S = Cᵀ·A (column pass), using LANES parallel MACs fed by one A-RAM read port and one packed coefficient-ROM read port. Results go to a single write port after an arithmetic right shift, with optional pixel clipping. It sits between the dequantised-block RAM and the pixel-output RAM, and the top-level controller drives it with a start/done handshake.

---
 rtl/idct_matrix_engine.sv | 196 +++++++++++++++++++
 tb/tb_idct_matrix_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_matrix_engine.sv
// N x N signed matrix-multiply engine for the IDCT: T = A*C (T_S=1) or S = C^T*A (T_S=0), LANES parallel MACs.
// Optional build macro MM_CLIP_EN: S-mode results saturate to [0,255]; undefined gives plain truncation in both modes.
module idct_matrix_engine #(
    parameter int unsigned N       = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned A_W     = 32,
    parameter int unsigned C_W     = 16,
    parameter int unsigned P_W     = 32,
    parameter int unsigned SHIFT_T = 8,
    parameter int unsigned SHIFT_S = 16
) (
    input  logic                           CLOCK_50_I,
    input  logic                           Resetn,
    input  logic                           MM_start,
    input  logic                           T_S,
    output logic                           MM_busy,
    output logic                           MM_done,
    output logic [2*$clog2(N)-1:0]         A_read_address,
    input  logic [A_W-1:0]                 A_read_data,
    output logic [$clog2(N*N/LANES)-1:0]   C_read_address,
    input  logic [LANES*C_W-1:0]           C_read_data,
    output logic [2*$clog2(N)-1:0]         P_write_address,
    output logic [P_W-1:0]                 P_write_data,
    output logic                           P_write_enable
);

    localparam int unsigned LOG_N  = $clog2(N);
    localparam int unsigned AD_W   = 2 * LOG_N;
    localparam int unsigned NL     = N / LANES;
    localparam int unsigned M_W    = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned CA_W   = $clog2(N * N / LANES);
    localparam int unsigned L_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PROD_W = A_W + C_W;
    localparam int unsigned ACC_W  = PROD_W + LOG_N;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             mode_t;
    logic [LOG_N-1:0] k_cnt, o_cnt, k1, o1, k2, o2, wr_o;
    logic [M_W-1:0]   m_cnt, m1, m2, wr_m;
    logic             v1, v2;
    logic             run_last_c, grp_done_c;
    logic [CA_W-1:0]  c_addr_c;

    logic signed [A_W-1:0]    a_s;
    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [ACC_W-1:0]  sum_c  [LANES];
    logic signed [ACC_W-1:0]  sh_c   [LANES];
    logic signed [ACC_W-1:0]  acc    [LANES];
    logic [P_W-1:0]           res_c  [LANES];
    logic [P_W-1:0]           wr_buf [LANES];
    logic [L_W-1:0]           wr_lane;
    logic                     wr_more;

    // Output address of lane l in group (o, m); o is the row in T mode and the column in S mode.
    function automatic logic [AD_W-1:0] p_addr(input logic t_mode, input logic [LOG_N-1:0] o,
                                               input logic [M_W-1:0] m, input logic [L_W-1:0] l);
        int unsigned idx;
        idx = 32'(m) * LANES + 32'(l);
        return t_mode ? AD_W'(32'(o) * N + idx) : AD_W'(idx * N + 32'(o));
    endfunction

    assign run_last_c = (k_cnt == LOG_N'(N - 1)) && (m_cnt == M_W'(NL - 1)) && (o_cnt == LOG_N'(N - 1));
    assign c_addr_c   = CA_W'(int'(k_cnt) * int'(NL) + int'(m_cnt));
    assign grp_done_c = v2 && (k2 == LOG_N'(N - 1));
    assign a_s        = A_read_data;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (MM_start) state_nxt = S_RUN;
            S_RUN:   if (run_last_c) state_nxt = S_DRAIN;
            S_DRAIN: if (!v1 && !v2 && !wr_more && P_write_enable) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            MM_busy <= 1'b0;
            MM_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            MM_busy <= (state_nxt != S_IDLE);
            MM_done <= (state_nxt == S_DONE);
        end
    end

    // Read-step sequencing: k is innermost, then lane group m, then row/column o
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            mode_t         <= 1'b0;
            k_cnt          <= '0;
            m_cnt          <= '0;
            o_cnt          <= '0;
            A_read_address <= '0;
            C_read_address <= '0;
            v1 <= 1'b0; k1 <= '0; m1 <= '0; o1 <= '0;
            v2 <= 1'b0; k2 <= '0; m2 <= '0; o2 <= '0;
        end else begin
            v1 <= 1'b0;
            if (state == S_IDLE && MM_start) begin
                mode_t <= T_S;
                k_cnt  <= '0;
                m_cnt  <= '0;
                o_cnt  <= '0;
            end else if (state == S_RUN) begin
                A_read_address <= mode_t ? {o_cnt, k_cnt} : {k_cnt, o_cnt};
                C_read_address <= c_addr_c;
                v1 <= 1'b1;
                k1 <= k_cnt;
                m1 <= m_cnt;
                o1 <= o_cnt;
                k_cnt <= k_cnt + LOG_N'(1);
                if (k_cnt == LOG_N'(N - 1)) begin
                    if (m_cnt == M_W'(NL - 1)) begin
                        m_cnt <= '0;
                        o_cnt <= o_cnt + LOG_N'(1);
                    end else begin
                        m_cnt <= m_cnt + M_W'(1);
                    end
                end
            end
            v2 <= v1;
            k2 <= k1;
            m2 <= m1;
            o2 <= o1;
        end
    end

    // MAC lanes plus shift / optional clip of the running sum
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            prod_c[l] = PROD_W'(a_s) * PROD_W'($signed(C_read_data[(LANES-1-l)*C_W +: C_W]));
            sum_c[l]  = (k2 == '0) ? ACC_W'(prod_c[l]) : acc[l] + ACC_W'(prod_c[l]);
            sh_c[l]   = mode_t ? (sum_c[l] >>> SHIFT_T) : (sum_c[l] >>> SHIFT_S);
`ifdef MM_CLIP_EN
            if (!mode_t && sh_c[l] < 0)
                res_c[l] = '0;
            else if (!mode_t && sh_c[l] > ACC_W'(255))
                res_c[l] = P_W'(255);
            else
                res_c[l] = P_W'(sh_c[l]);
`else
            res_c[l] = P_W'(sh_c[l]);
`endif
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else if (v2) begin
            for (int l = 0; l < LANES; l++) acc[l] <= sum_c[l];
        end
    end

    // Lane 0 is written on the snapshot edge; the rest drain from the buffer one per cycle
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            for (int l = 0; l < LANES; l++) wr_buf[l] <= '0;
            wr_o            <= '0;
            wr_m            <= '0;
            wr_lane         <= '0;
            wr_more         <= 1'b0;
            P_write_enable  <= 1'b0;
            P_write_address <= '0;
            P_write_data    <= '0;
        end else if (grp_done_c) begin
            for (int l = 0; l < LANES; l++) wr_buf[l] <= res_c[l];
            wr_o            <= o2;
            wr_m            <= m2;
            wr_lane         <= L_W'(1);
            wr_more         <= (LANES > 1);
            P_write_enable  <= 1'b1;
            P_write_address <= p_addr(mode_t, o2, m2, '0);
            P_write_data    <= res_c[0];
        end else if (wr_more) begin
            wr_lane         <= wr_lane + L_W'(1);
            wr_more         <= (wr_lane != L_W'(LANES - 1));
            P_write_enable  <= 1'b1;
            P_write_address <= p_addr(mode_t, wr_o, wr_m, wr_lane);
            P_write_data    <= wr_buf[wr_lane];
        end else begin
            P_write_enable  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idct_matrix_engine.sv
// Scoreboard bench for idct_matrix_engine: expected writes are queued at start and popped per write strobe.
module tb_idct_matrix_engine;

    localparam int unsigned N          = 8;
    localparam int unsigned LANES      = 4;
    localparam int unsigned A_W        = 32;
    localparam int unsigned C_W        = 16;
    localparam int unsigned P_W        = 32;
    localparam int unsigned SHIFT_T    = 8;
    localparam int unsigned SHIFT_S    = 16;
    localparam int unsigned LOG_N      = $clog2(N);
    localparam int unsigned NL         = N / LANES;
    localparam int unsigned CA_W       = $clog2(N * N / LANES);
    localparam int unsigned RUN_CYCLES = N * N * N / LANES + LANES + 2;

    logic                    CLOCK_50_I = 1'b0;
    logic                    Resetn;
    logic                    MM_start;
    logic                    T_S;
    logic                    MM_busy;
    logic                    MM_done;
    logic [2*LOG_N-1:0]      A_read_address;
    logic [A_W-1:0]          A_read_data;
    logic [CA_W-1:0]         C_read_address;
    logic [LANES*C_W-1:0]    C_read_data;
    logic [2*LOG_N-1:0]      P_write_address;
    logic [P_W-1:0]          P_write_data;
    logic                    P_write_enable;

    idct_matrix_engine #(
        .N(N), .LANES(LANES), .A_W(A_W), .C_W(C_W), .P_W(P_W),
        .SHIFT_T(SHIFT_T), .SHIFT_S(SHIFT_S)
    ) dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .Resetn          (Resetn),
        .MM_start        (MM_start),
        .T_S             (T_S),
        .MM_busy         (MM_busy),
        .MM_done         (MM_done),
        .A_read_address  (A_read_address),
        .A_read_data     (A_read_data),
        .C_read_address  (C_read_address),
        .C_read_data     (C_read_data),
        .P_write_address (P_write_address),
        .P_write_data    (P_write_data),
        .P_write_enable  (P_write_enable)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic signed [A_W-1:0] a_mem [N*N];
    logic signed [C_W-1:0] c_mem [N][N];
    int                    exp_addr_q [$];
    logic [P_W-1:0]        exp_data_q [$];
    logic [N*N-1:0]        written;
    int unsigned           wr_count;
    int unsigned           done_cnt;
    int unsigned           n_tests = 0;
    int unsigned           n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*C_W-1:0] c_word(input logic [CA_W-1:0] addr);
        int unsigned k, m;
        logic [LANES*C_W-1:0] w;
        k = 32'(addr) / NL;
        m = 32'(addr) % NL;
        w = '0;
        for (int l = 0; l < LANES; l++)
            w[(LANES-1-l)*C_W +: C_W] = c_mem[k][m*LANES + l];
        return w;
    endfunction

    always @(posedge CLOCK_50_I) begin
        A_read_data <= a_mem[A_read_address];
        C_read_data <= c_word(C_read_address);
    end

    function automatic logic [63:0] outs();
        return 64'({MM_busy, MM_done, A_read_address, C_read_address,
                    P_write_address, P_write_data, P_write_enable});
    endfunction

    // Reference matrix product in the order the engine is expected to emit it
    task automatic push_expected(input bit mode_t);
        int o, m, col, addr;
        longint acc, res;
        for (int q = 0; q < N * N / LANES; q++) begin
            o = q / NL;
            m = q % NL;
            for (int l = 0; l < LANES; l++) begin
                col = m * LANES + l;
                acc = 0;
                for (int k = 0; k < N; k++) begin
                    if (mode_t) acc += longint'(a_mem[o*N + k]) * longint'(c_mem[k][col]);
                    else        acc += longint'(c_mem[k][col]) * longint'(a_mem[k*N + o]);
                end
                addr = mode_t ? (o * N + col) : (col * N + o);
                res  = mode_t ? (acc >>> SHIFT_T) : (acc >>> SHIFT_S);
`ifdef MM_CLIP_EN
                if (!mode_t) res = (res < 0) ? 64'sd0 : ((res > 255) ? 64'sd255 : res);
`endif
                exp_addr_q.push_back(addr);
                exp_data_q.push_back(32'(res));
            end
        end
    endtask

    always @(negedge CLOCK_50_I) begin
        int ea;
        logic [P_W-1:0] ed;
        if (Resetn && P_write_enable) begin
            wr_count++;
            check("wr_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 64'(P_write_address), 64'(ea));
                check("wr_data", 64'(P_write_data), 64'(ed));
            end
            check("wr_once", 64'(written[P_write_address]), 64'd0);
            written[P_write_address] = 1'b1;
        end
        if (Resetn && MM_done) done_cnt++;
    end

    // Starts a run on the next rising edge; returns #1 after the edge where MM_done falls
    task automatic run_mm(input bit mode_t, input bit hold_start, input string tag);
        int n;
        bit seen;
        written  = '0;
        wr_count = 0;
        done_cnt = 0;
        push_expected(mode_t);
        MM_start = 1'b1;
        T_S      = mode_t;
        @(posedge CLOCK_50_I); #1;
        if (!hold_start) MM_start = 1'b0;
        check({tag, "_busy_on"}, 64'(MM_busy), 64'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < int'(RUN_CYCLES) + 20) begin
            @(posedge CLOCK_50_I); #1;
            n++;
            if (n == 5) T_S = ~mode_t;
            if (MM_done) seen = 1'b1;
        end
        T_S = mode_t;
        check({tag, "_done_cyc"}, 64'(n), 64'(RUN_CYCLES));
        check({tag, "_busy_at_done"}, 64'(MM_busy), 64'd1);
        @(posedge CLOCK_50_I); #1;
        check({tag, "_idle"}, 64'({MM_busy, MM_done}), 64'd0);
        check({tag, "_wr_cnt"}, 64'(wr_count), 64'(N * N));
        check({tag, "_sb_left"}, 64'(exp_addr_q.size()), 64'd0);
        check({tag, "_all_addr"}, 64'(&written), 64'd1);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic fill_ident_t();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_mem[r*N + c] = A_W'(r * N + c);
                c_mem[r][c]    = (r == c) ? C_W'(256) : '0;
            end
    endtask

    task automatic fill_scale_s();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_mem[r*N + c] = A_W'(-(r * N + c) * 65536);
                c_mem[r][c]    = (r == c) ? C_W'(1) : '0;
            end
    endtask

    task automatic fill_round();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_mem[r*N + c] = -1;
                c_mem[r][c]    = C_W'(1);
            end
    endtask

    task automatic fill_clip();
        int vals [6];
        vals = '{300, -5, 255, 256, -1, 17};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_mem[r*N + c] = A_W'(vals[(r * N + c) % 6] * 65536);
                c_mem[r][c]    = (r == c) ? C_W'(1) : '0;
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_mem[r*N + c] = A_W'($urandom);
                c_mem[r][c]    = C_W'($urandom);
            end
    endtask

    task automatic reset_mid_run();
        fill_random();
        push_expected(1'b1);
        written  = '0;
        wr_count = 0;
        MM_start = 1'b1;
        T_S      = 1'b1;
        @(posedge CLOCK_50_I); #1;
        MM_start = 1'b0;
        repeat (50) @(posedge CLOCK_50_I);
        #1 Resetn = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 64'd0);
        check("rst_mid_wrs", 64'(wr_count), 64'd20);
        exp_addr_q.delete();
        exp_data_q.delete();
        written = '0;
        @(negedge CLOCK_50_I);
        Resetn = 1'b1;
        @(posedge CLOCK_50_I); #1;
        check("rst_mid_idle", 64'(MM_busy), 64'd0);
    endtask

    initial begin
        Resetn   = 1'b0;
        MM_start = 1'b0;
        T_S      = 1'b0;
        written  = '0;
        wr_count = 0;
        done_cnt = 0;
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        check("rst_outs", outs(), 64'd0);
        @(negedge CLOCK_50_I);
        Resetn = 1'b1;

        fill_ident_t();  run_mm(1'b1, 1'b0, "ident_t");
        fill_scale_s();  run_mm(1'b0, 1'b0, "scale_s");
        fill_round();    run_mm(1'b1, 1'b0, "round_t");
        fill_clip();     run_mm(1'b0, 1'b0, "clip_s");
        fill_random();   run_mm(1'b1, 1'b0, "rand_t");
        fill_random();   run_mm(1'b0, 1'b1, "hold_s");
        fill_random();   run_mm(1'b1, 1'b0, "restart_t");
        reset_mid_run();
        fill_ident_t();  run_mm(1'b1, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
